shift_unit_pipe: RTL and testbench
==================================

SHIFT_UNIT_PIPE -- requirements
Module: shift_unit_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits.
REQ-002 SHALL have parameter SHAMT_W, default 5, shift-amount width; WIDTH SHALL equal 2**SHAMT_W.
REQ-003 SHALL have port Clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port Rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, input operand valid.
REQ-006 SHALL have port in_ready, output, 1, unit can accept an operand this cycle.
REQ-007 SHALL have port in_data, input, WIDTH, operand.
REQ-008 SHALL have port in_shamt, input, SHAMT_W, shift amount.
REQ-009 SHALL have port in_op, input, 2, operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
REQ-010 SHALL have port out_valid, output, 1, result valid.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-012 SHALL have port out_data, output, WIDTH, shifted result.
REQ-013 SHALL have port out_zero, output, 1, high when out_data is all zeros.

Function
REQ-014 SHALL implement a logarithmic shifter of SHAMT_W levels; level k shifts by 2**k when shamt bit k is set; a register SHALL follow every level.
REQ-015 SHALL carry valid, op and remaining shamt bits alongside data through every stage.
REQ-016 Transfer SHALL occur on a port only when valid and ready are both high in the same cycle.
REQ-017 Latency SHALL be exactly SHAMT_W cycles from input transfer to out_valid (5 at defaults) when not stalled.
REQ-018 Throughput SHALL be one operand per cycle when out_ready is held high.
REQ-019 stall SHALL be out_valid AND NOT out_ready; during stall all stages hold, out_data/out_zero SHALL stay stable.
REQ-020 in_ready SHALL equal NOT stall (combinational); a presented operand SHALL be neither lost nor duplicated.
REQ-021 SLL/SRL SHALL zero-fill; SRA SHALL fill with operand bit WIDTH-1 at every level.
REQ-022 shamt 0 SHALL pass the operand unchanged for every op.
REQ-023 Bubbles (in_valid low) SHALL propagate as invalid stages; they SHALL NOT be compressed.
REQ-024 out_zero SHALL be registered with out_data and valid only when out_valid is high.

Reset
REQ-025 Rst_n low SHALL asynchronously clear all stage valid bits, data, op and shamt registers; out_valid=0, out_data=0, out_zero=0.
REQ-026 in_ready SHALL be 1 during and after reset (no stall possible).
REQ-027 Reset mid-operation SHALL discard all in-flight operands; no result emerges for them after release.
REQ-028 Operands SHALL be accepted on the first rising edge after Rst_n deasserts.

Configuration
REQ-029 Macro SHIFT_ROTATE_EN defined: op 11 SHALL rotate left, bits shifted out of MSB re-entering at LSB.
REQ-030 Macro SHIFT_ROTATE_EN undefined: op 11 SHALL behave exactly as SLL; no rotate logic SHALL be synthesised.

Verification
REQ-031 SLL in_data=1,8,54 shamt=2 back-to-back, out_ready=1 -> out_data 4,32,216 on cycles 5,6,7 after first transfer.
REQ-032 SRA in_data=0x80000000 shamt=4 -> 0xF8000000; SRL same -> 0x08000000; SLL 0x1 shamt=31 -> 0x80000000.
REQ-033 ROL in_data=0x80000001 shamt=1 -> 0x00000003 with SHIFT_ROTATE_EN, 0x00000002 without.
REQ-034 Pipeline full, out_ready low 3 cycles -> in_ready low, out_data stable, all results delivered in order after release.
REQ-035 SRL 0x0000000F shamt=4 -> out_data 0, out_zero 1; shamt=0 any op -> operand unchanged.
REQ-036 Assert Rst_n low with 3 operands in flight -> out_valid 0 immediately, no stale results after release, new operand correct after 5 cycles.

Source files
------------

// File: rtl/shift_unit_pipe.sv
// ============================================================================
//  Module      : shift_unit_pipe
//  Description : Pipelined logarithmic shifter (SLL/SRL/SRA/ROL) with
//                valid/ready handshake and a whole-pipe stall.
//                Optional feature macro: SHIFT_ROTATE_EN (op 11 rotates left;
//                when undefined op 11 behaves as SLL).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_unit_pipe #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5     // WIDTH must equal 2**SHAMT_W
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_zero
);

    localparam logic [1:0] c_OP_SLL = 2'b00;
    localparam logic [1:0] c_OP_SRL = 2'b01;
    localparam logic [1:0] c_OP_SRA = 2'b10;
    localparam logic [1:0] c_OP_ROL = 2'b11;

    // One shifter level: fixed distance amt, operation selected by op.
    function automatic logic [WIDTH-1:0] f_level(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       op,
        input int               amt
    );
        logic [WIDTH-1:0] r;
        r = d << amt;
        case (op)
            c_OP_SLL: r = d << amt;
            c_OP_SRL: r = d >> amt;
            c_OP_SRA: r = $unsigned($signed(d) >>> amt);
`ifdef SHIFT_ROTATE_EN
            c_OP_ROL: r = (d << amt) | (d >> (WIDTH - amt));
`else
            c_OP_ROL: r = d << amt;
`endif
            default:  r = d << amt;
        endcase
        return r;
    endfunction

    logic               w_stall;
    logic [WIDTH-1:0]   w_data_s  [SHAMT_W+1];
    logic               w_valid_s [SHAMT_W+1];
    logic [1:0]         w_op_s    [SHAMT_W];
    logic [SHAMT_W-1:0] w_shamt_s [SHAMT_W];
    logic               w_zero;
    logic               w_unused_shamt;

    // A stalled output freezes every stage, so bubbles are never squeezed out.
    assign w_stall   = w_valid_s[SHAMT_W] & ~out_ready;
    assign in_ready  = ~w_stall;

    assign w_data_s[0]  = in_data;
    assign w_valid_s[0] = in_valid;
    assign w_op_s[0]    = in_op;
    assign w_shamt_s[0] = in_shamt;

    generate
        for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
            localparam int AMT = 1 << k;

            logic [WIDTH-1:0] data_d;
            logic [WIDTH-1:0] data_q;
            logic             valid_q;

            always_comb begin
                data_d = w_data_s[k];
                if (w_shamt_s[k][k])
                    data_d = f_level(w_data_s[k], w_op_s[k], AMT);
            end

            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else if (!w_stall) begin
                    data_q  <= data_d;
                    valid_q <= w_valid_s[k];
                end
            end

            assign w_data_s[k+1]  = data_q;
            assign w_valid_s[k+1] = valid_q;

            if (k < SHAMT_W - 1) begin : g_carry
                logic [1:0]         op_q;
                logic [SHAMT_W-1:0] shamt_q;

                always_ff @(posedge Clk or negedge Rst_n) begin
                    if (!Rst_n) begin
                        op_q    <= '0;
                        shamt_q <= '0;
                    end else if (!w_stall) begin
                        op_q    <= w_op_s[k];
                        shamt_q <= w_shamt_s[k];
                    end
                end

                assign w_op_s[k+1]    = op_q;
                assign w_shamt_s[k+1] = shamt_q;
            end else begin : g_last
                logic zero_d;
                logic zero_q;

                // Flag is only ever set alongside a valid result.
                assign zero_d = w_valid_s[k] & (data_d == '0);

                always_ff @(posedge Clk or negedge Rst_n) begin
                    if (!Rst_n)
                        zero_q <= 1'b0;
                    else if (!w_stall)
                        zero_q <= zero_d;
                end

                assign w_zero = zero_q;
            end
        end
    endgenerate

    // Low shift-amount bits have already been consumed by the last level.
    assign w_unused_shamt = ^w_shamt_s[SHAMT_W-1][SHAMT_W-2:0];

    assign out_valid = w_valid_s[SHAMT_W];
    assign out_data  = w_data_s[SHAMT_W];
    assign out_zero  = w_zero;

endmodule

`default_nettype wire

// File: tb/tb_shift_unit_pipe.sv
// ============================================================================
//  Module      : tb_shift_unit_pipe
//  Description : Randomised scoreboard bench for shift_unit_pipe.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_unit_pipe;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    logic               Clk = 1'b0;
    logic               Rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data = '0;
    logic [SHAMT_W-1:0] in_shamt = '0;
    logic [1:0]         in_op = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [WIDTH-1:0]   out_data;
    logic               out_zero;

    shift_unit_pipe #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             zero;
        int               tcyc;
        bit               lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   or_mode  = 0;   // 0: ready high, 1: random, 2: ready low
    bit   chk_lat  = 1'b0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain shift/rotate arithmetic on the whole operand.
    function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] d,
                                                   input int s, input logic [1:0] op);
        logic [2*WIDTH-1:0] w;
        logic [WIDTH-1:0]   r;
        case (op)
            2'b00: r = d << s;
            2'b01: r = d >> s;
            2'b10: r = $unsigned($signed(d) >>> s);
            default: begin
`ifdef SHIFT_ROTATE_EN
                w = {d, d} << s;
                r = w[2*WIDTH-1:WIDTH];
`else
                w = '0;
                r = d << s;
`endif
            end
        endcase
        return r;
    endfunction

    // Downstream ready generator.
    initial begin
        forever begin
            @(posedge Clk);
            #1;
            case (or_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every output transfer.
    initial begin
        exp_t             e;
        bit               prev_stall = 1'b0;
        logic [WIDTH-1:0] prev_data  = '0;
        logic             prev_zero  = 1'b0;
        forever begin
            @(negedge Clk);
            if (Rst_n) begin
                chk("in_ready_vs_stall", in_ready, !(out_valid && !out_ready));
                if (prev_stall) begin
                    chk("stall_data_hold", out_data, prev_data);
                    chk("stall_zero_hold", out_zero, prev_zero);
                end
                if (!out_valid)
                    chk("zero_when_invalid", out_zero, 1'b0);
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output: got %0h expected none", out_data);
                    end else begin
                        e = sb.pop_front();
                        chk("out_data", out_data, e.data);
                        chk("out_zero", out_zero, e.zero);
                        if (e.lat)
                            chk("latency", cyc + 1 - e.tcyc, SHAMT_W);
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_zero  = out_zero;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // Present one operand, starting just after a rising edge, until accepted.
    task automatic send(input logic [WIDTH-1:0] d, input int s, input logic [1:0] op);
        bit   ok;
        exp_t e;
        in_data  = d;
        in_shamt = s[SHAMT_W-1:0];
        in_op    = op;
        in_valid = 1'b1;
        do begin
            @(negedge Clk);
            ok = in_ready;
            if (ok) begin
                e.data = ref_shift(d, s, op);
                e.zero = (e.data == '0);
                e.tcyc = cyc + 1;
                e.lat  = chk_lat;
                sb.push_back(e);
            end
            @(posedge Clk);
            #1;
        end while (!ok);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic drain(input int budget);
        int t = 0;
        while (sb.size() != 0 && t < budget) begin
            idle(1);
            t++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    typedef struct {
        logic [WIDTH-1:0] d;
        int               s;
        logic [1:0]       op;
    } vec_t;

    initial begin
        vec_t dir[$];
        logic [WIDTH-1:0] d;
        int s;
        logic [1:0] op;

        // Reset state.
        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_zero", out_zero, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;

        // Back-to-back SLL with exact latency.
        chk_lat = 1'b1;
        send(32'd1, 2, 2'b00);
        send(32'd8, 2, 2'b00);
        send(32'd54, 2, 2'b00);
        drain(50);

        // Directed corner operands.
        dir.push_back('{32'h8000_0000, 4, 2'b10});
        dir.push_back('{32'h8000_0000, 4, 2'b01});
        dir.push_back('{32'h0000_0001, 31, 2'b00});
        dir.push_back('{32'h8000_0001, 1, 2'b11});
        dir.push_back('{32'h0000_000F, 4, 2'b01});
        dir.push_back('{32'hFFFF_FFFF, 31, 2'b11});
        for (int i = 0; i < 4; i++)
            dir.push_back('{32'hA5A5_1234, 0, i[1:0]});
        foreach (dir[i])
            send(dir[i].d, dir[i].s, dir[i].op);
        drain(50);

        // Randomised traffic with bubbles and random backpressure.
        chk_lat = 1'b0;
        or_mode = 1;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 7))
                0:       d = 32'h8000_0000;
                1:       d = $urandom_range(0, 15);
                default: d = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       s = 0;
                1:       s = 31;
                default: s = $urandom_range(0, 31);
            endcase
            op = 2'($urandom_range(0, 3));
            send(d, s, op);
            if ($urandom_range(0, 3) == 0)
                idle($urandom_range(1, 2));
        end
        or_mode = 0;
        drain(400);

        // Full pipe held off for three cycles.
        or_mode = 2;
        idle(2);
        for (int i = 0; i < SHAMT_W; i++)
            send(32'h0000_0100 << i, i, 2'b01);
        idle(1);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk("stall_in_ready_low", in_ready, 1'b0);
            chk("stall_out_valid", out_valid, 1'b1);
            @(posedge Clk);
            #1;
        end
        or_mode = 0;
        drain(50);

        // Reset with three operands in flight.
        send(32'h1234_5678, 3, 2'b00);
        send(32'h0000_00F0, 4, 2'b01);
        send(32'hF000_0000, 8, 2'b10);
        Rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_out_data", out_data, '0);
        chk("midrst_in_ready", in_ready, 1'b1);
        sb.delete();
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        chk_lat = 1'b1;
        send(32'h0000_0ACE, 5, 2'b00);
        drain(50);
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
